// File: rtl/afe_att_spi_writer_pkg.sv
// Shared types and constants for the AFE step-attenuator SPI writer.
package dsbpm_afe_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      LE_SETUP,
      LE_PULSE,
      GUARD
   } afe_spi_state_t;

   localparam int AFE_ATT_BITS = 6;

   // Counter width that stays at least one bit wide for degenerate ranges.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/afe_att_spi_writer_if.sv
// CSR-side request/status bundle of the attenuator SPI writer.
interface afe_att_spi_writer_if
   import dsbpm_afe_pkg::*;
#(
   parameter int DATA_WIDTH = 24,
   parameter int AFE_COUNT  = 2
);
   localparam int SEL_W = cnt_width(AFE_COUNT);

   logic                  start;
   logic [SEL_W-1:0]      afeSel;
   logic [DATA_WIDTH-1:0] wrData;
   logic                  clrOverrun;
   logic                  busy;
   logic                  done;
   logic                  overrun;

   modport master (
      output start, afeSel, wrData, clrOverrun,
      input  busy, done, overrun
   );

   modport slave (
      input  start, afeSel, wrData, clrOverrun,
      output busy, done, overrun
   );
endinterface

// File: rtl/afe_att_spi_writer_tick.sv
// Half-period strobe: tick is high in the last cycle of every CLK_DIV-cycle phase.
module afe_spi_tick
   import dsbpm_afe_pkg::*;
#(
   parameter int CLK_DIV = 5
) (
   input  logic sysClk,
   input  logic sysReset,
   input  logic restart,
   output logic tick
);
   localparam int CW = cnt_width(CLK_DIV);

   logic [CW-1:0] cnt;

   assign tick = (cnt == CW'(CLK_DIV - 1));

   always_ff @(posedge sysClk or posedge sysReset) begin
      if (sysReset) begin
         cnt <= '0;
      end else if (restart || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/afe_att_spi_writer.sv
// Write-only SPI master: shifts one attenuator word into the selected AFE board, then latches it.
module afe_att_spi_writer
   import dsbpm_afe_pkg::*;
#(
   parameter int DATA_WIDTH = 24,
   parameter int CLK_DIV    = 5,
   parameter int AFE_COUNT  = 2
) (
   input  logic                 sysClk,
   input  logic                 sysReset,
   afe_att_spi_writer_if.slave  csr,
   output logic [AFE_COUNT-1:0] AFE_SPI_CLK,
   output logic [AFE_COUNT-1:0] AFE_SPI_SDI,
   output logic [AFE_COUNT-1:0] AFE_SPI_LE
);
   localparam int SEL_W = cnt_width(AFE_COUNT);
   localparam int BIT_W = $clog2(DATA_WIDTH + 1);

   afe_spi_state_t        state, state_n;
   logic                  phase_hi, phase_hi_n;
   logic [BIT_W-1:0]      bit_cnt, bit_cnt_n;
   logic [DATA_WIDTH-1:0] shift_reg, shift_n;
   logic [SEL_W-1:0]      sel, sel_n;
   logic                  tick;
   logic                  done_n, overrun_n;
   logic [AFE_COUNT-1:0]  clk_n, sdi_n, le_n;

   afe_spi_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .sysClk   (sysClk),
      .sysReset (sysReset),
      .restart  (state == IDLE),
      .tick     (tick)
   );

   always_comb begin
      state_n    = state;
      phase_hi_n = phase_hi;
      bit_cnt_n  = bit_cnt;
      shift_n    = shift_reg;
      sel_n      = sel;
      done_n     = 1'b0;
      case (state)
         IDLE: begin
            if (csr.start) begin
               state_n    = SHIFT;
               phase_hi_n = 1'b0;
               bit_cnt_n  = '0;
               shift_n    = csr.wrData;
               sel_n      = csr.afeSel;
            end
         end
         SHIFT: begin
            if (tick) begin
               if (!phase_hi) begin
                  phase_hi_n = 1'b1;
               end else begin
                  phase_hi_n = 1'b0;
                  bit_cnt_n  = bit_cnt + 1'b1;
                  // The last bit stays on SDI through latch setup, so no shift on exit.
                  if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
                     state_n = LE_SETUP;
                  end else begin
                     shift_n = shift_reg << 1;
                  end
               end
            end
         end
         LE_SETUP: if (tick) state_n = LE_PULSE;
         LE_PULSE: if (tick) state_n = GUARD;
         GUARD: begin
            if (tick) begin
               state_n = IDLE;
               done_n  = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      overrun_n = csr.overrun;
      if (csr.start && (state != IDLE)) begin
         overrun_n = 1'b1;
      end else if (csr.clrOverrun) begin
         overrun_n = 1'b0;
      end
   end

   // Pin values are derived from the next state so they can be registered with no lag.
   always_comb begin
      clk_n = '0;
      sdi_n = '0;
      le_n  = '0;
      for (int i = 0; i < AFE_COUNT; i++) begin
         if (sel_n == SEL_W'(i)) begin
            clk_n[i] = (state_n == SHIFT) && phase_hi_n;
            sdi_n[i] = ((state_n == SHIFT) || (state_n == LE_SETUP) || (state_n == LE_PULSE))
                       && shift_n[DATA_WIDTH-1];
            le_n[i]  = (state_n == LE_PULSE);
         end
      end
   end

   always_ff @(posedge sysClk or posedge sysReset) begin
      if (sysReset) begin
         state       <= IDLE;
         phase_hi    <= 1'b0;
         bit_cnt     <= '0;
         csr.busy    <= 1'b0;
         csr.done    <= 1'b0;
         csr.overrun <= 1'b0;
         AFE_SPI_CLK <= '0;
         AFE_SPI_SDI <= '0;
         AFE_SPI_LE  <= '0;
      end else begin
         state       <= state_n;
         phase_hi    <= phase_hi_n;
         bit_cnt     <= bit_cnt_n;
         csr.busy    <= (state_n != IDLE);
         csr.done    <= done_n;
         csr.overrun <= overrun_n;
         AFE_SPI_CLK <= clk_n;
         AFE_SPI_SDI <= sdi_n;
         AFE_SPI_LE  <= le_n;
      end
   end

   always_ff @(posedge sysClk) begin
      shift_reg <= shift_n;
      sel       <= sel_n;
   end
endmodule

// File: tb/tb_afe_att_spi_writer.sv
// Bench for afe_att_spi_writer: cycle-level waveform reference plus directed and random transfers.
module tb_afe_att_spi_writer;
   localparam int W   = 24;
   localparam int D   = 5;
   localparam int TOT = 2 * D * W + 3 * D;

   logic sysClk = 1'b0;
   logic sysReset;
   logic [1:0] afe_clk, afe_sdi, afe_le;
   logic [1:0] s_clk, s_sdi, s_le;

   int n_checks = 0;
   int n_errors = 0;

   afe_att_spi_writer_if #(.DATA_WIDTH(W), .AFE_COUNT(2)) csr ();
   afe_att_spi_writer_if #(.DATA_WIDTH(6), .AFE_COUNT(2)) s_csr ();

   afe_att_spi_writer #(.DATA_WIDTH(W), .CLK_DIV(D), .AFE_COUNT(2)) u_dut (
      .sysClk      (sysClk),
      .sysReset    (sysReset),
      .csr         (csr.slave),
      .AFE_SPI_CLK (afe_clk),
      .AFE_SPI_SDI (afe_sdi),
      .AFE_SPI_LE  (afe_le)
   );

   afe_att_spi_writer #(.DATA_WIDTH(6), .CLK_DIV(1), .AFE_COUNT(2)) u_small (
      .sysClk      (sysClk),
      .sysReset    (sysReset),
      .csr         (s_csr.slave),
      .AFE_SPI_CLK (s_clk),
      .AFE_SPI_SDI (s_sdi),
      .AFE_SPI_LE  (s_le)
   );

   always #5 sysClk = ~sysClk;

   initial begin
      #1000000;
      $display("FAIL global_timeout: got no finish, required finish before 1000000");
      $fatal(1);
   end

   // Reference: a transfer is just an index k into a fixed-length frame.
   logic         m_active, m_done, m_over;
   int           m_k;
   logic [W-1:0] m_word;
   logic         m_sel;

   always @(posedge sysClk or posedge sysReset) begin
      if (sysReset) begin
         m_active <= 1'b0;
         m_done   <= 1'b0;
         m_over   <= 1'b0;
         m_k      <= 0;
      end else begin
         m_done <= 1'b0;
         if (m_active) begin
            if (m_k == TOT - 1) begin
               m_active <= 1'b0;
               m_done   <= 1'b1;
            end else begin
               m_k <= m_k + 1;
            end
         end else if (csr.start) begin
            m_active <= 1'b1;
            m_k      <= 0;
            m_word   <= csr.wrData;
            m_sel    <= csr.afeSel;
         end
         if (csr.start && m_active) m_over <= 1'b1;
         else if (csr.clrOverrun)   m_over <= 1'b0;
      end
   end

   logic [W-1:0] cap [2];
   int           ncap [2];
   int           nle [2];
   int           busy_cnt;
   logic [1:0]   pclk = '0, ple = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cycle();
      logic [1:0] ec, es, el, em;
      logic [8:0] got, exp;
      int k;
      @(negedge sysClk);
      ec = '0; es = '0; el = '0; em = 2'b11;
      if (m_active) begin
         k = m_k;
         if (k < 2 * D * W) begin
            ec[m_sel] = ((k % (2 * D)) >= D);
            es[m_sel] = m_word[W - 1 - k / (2 * D)];
         end else if (k < 2 * D * W + D) begin
            es[m_sel] = m_word[0];
         end else if (k < 2 * D * W + 2 * D) begin
            el[m_sel] = 1'b1;
            em[m_sel] = 1'b0;
         end
      end
      got = {csr.busy, csr.done, csr.overrun, afe_clk, afe_sdi & em, afe_le};
      exp = {m_active, m_done, m_over, ec, es, el};
      check("cycle", 64'(got), 64'(exp));
      if (csr.busy) busy_cnt++;
      for (int b = 0; b < 2; b++) begin
         if (afe_clk[b] && !pclk[b]) begin
            cap[b] = {cap[b][W-2:0], afe_sdi[b]};
            ncap[b]++;
         end
         if (afe_le[b] && !ple[b]) nle[b]++;
      end
      pclk = afe_clk;
      ple  = afe_le;
   endtask

   task automatic launch(input logic sel, input logic [W-1:0] word);
      csr.afeSel = sel;
      csr.wrData = word;
      csr.start  = 1'b1;
      busy_cnt   = 0;
      for (int b = 0; b < 2; b++) begin
         cap[b] = '0; ncap[b] = 0; nle[b] = 0;
      end
      cycle();
      csr.start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < TOT + 20; i++) begin
         if (csr.done) return;
         cycle();
      end
      check({tag, "_timeout"}, 64'(csr.done), 64'(1));
   endtask

   initial begin
      logic [W-1:0] w;
      logic [5:0]   scap;
      int           sb, tog_bad, sle;
      logic         sdone, sp_clk, sp_le;

      sysReset = 1'b1;
      csr.start = 1'b0; csr.afeSel = '0; csr.wrData = '0; csr.clrOverrun = 1'b0;
      s_csr.start = 1'b0; s_csr.afeSel = '0; s_csr.wrData = '0; s_csr.clrOverrun = 1'b0;
      for (int b = 0; b < 2; b++) begin
         cap[b] = '0; ncap[b] = 0; nle[b] = 0;
      end
      busy_cnt = 0;
      repeat (3) cycle();
      check("reset_state", 64'({csr.busy, csr.done, csr.overrun, afe_clk, afe_sdi, afe_le}), 64'(0));
      sysReset = 1'b0;
      repeat (3) cycle();

      // Single transfer to board 0
      launch(1'b0, 24'hA53C0F);
      wait_done("t1");
      check("t1_busy_len", 64'(busy_cnt), 64'(TOT));
      check("t1_word", 64'(cap[0]), 64'(24'hA53C0F));
      check("t1_nbits", 64'(ncap[0]), 64'(W));
      check("t1_le0", 64'(nle[0]), 64'(1));
      check("t1_quiet1", 64'(ncap[1] + nle[1]), 64'(0));
      cycle();

      // Back-to-back on board 1, second start in the done cycle
      launch(1'b1, 24'hFFFFFF);
      wait_done("t2a");
      check("t2a_word", 64'(cap[1]), 64'(24'hFFFFFF));
      check("t2a_le1", 64'(nle[1]), 64'(1));
      launch(1'b1, 24'h000000);
      check("t2_accept", 64'(csr.busy), 64'(1));
      wait_done("t2b");
      check("t2b_busy_len", 64'(busy_cnt), 64'(TOT));
      check("t2b_word", 64'(cap[1]), 64'(0));
      check("t2b_nbits", 64'(ncap[1]), 64'(W));
      check("t2b_le1", 64'(nle[1]), 64'(1));
      check("t2_quiet0", 64'(ncap[0] + nle[0]), 64'(0));
      cycle();

      // Overrun: start while busy is ignored and sets the sticky flag
      w = 24'($urandom);
      launch(1'b0, w);
      repeat (49) cycle();
      csr.wrData = ~w; csr.afeSel = 1'b1; csr.start = 1'b1;
      cycle();
      csr.start = 1'b0;
      check("t3_overrun_set", 64'(csr.overrun), 64'(1));
      wait_done("t3");
      check("t3_word", 64'(cap[0]), 64'(w));
      check("t3_quiet1", 64'(ncap[1] + nle[1]), 64'(0));
      csr.clrOverrun = 1'b1;
      cycle();
      csr.clrOverrun = 1'b0;
      check("t3_overrun_clr", 64'(csr.overrun), 64'(0));
      launch(1'b1, 24'($urandom));
      repeat (10) cycle();
      csr.start = 1'b1; csr.clrOverrun = 1'b1;
      cycle();
      csr.start = 1'b0; csr.clrOverrun = 1'b0;
      check("t3_set_wins", 64'(csr.overrun), 64'(1));
      wait_done("t3b");
      csr.clrOverrun = 1'b1;
      cycle();
      csr.clrOverrun = 1'b0;

      // Random requests, selects, words and clears
      for (int i = 0; i < 1500; i++) begin
         csr.start      = ($urandom_range(0, 99) < 3);
         csr.afeSel     = 1'($urandom_range(0, 1));
         csr.wrData     = 24'($urandom);
         csr.clrOverrun = ($urandom_range(0, 49) == 0);
         cycle();
      end
      csr.start = 1'b0; csr.clrOverrun = 1'b0;
      for (int i = 0; i < TOT + 5 && csr.busy; i++) cycle();
      check("rand_idle", 64'(csr.busy), 64'(0));

      // Asynchronous reset in the middle of bit 10
      launch(1'b0, 24'($urandom));
      repeat (102) cycle();
      @(posedge sysClk);
      #2 sysReset = 1'b1;
      #1 check("t4_async_zero",
               64'({csr.busy, csr.done, csr.overrun, afe_clk, afe_sdi, afe_le}), 64'(0));
      cycle();
      cycle();
      sysReset = 1'b0;
      repeat (5) cycle();
      check("t4_no_le", 64'(nle[0] + nle[1]), 64'(0));
      w = 24'($urandom);
      launch(1'b0, w);
      wait_done("t4");
      check("t4_word", 64'(cap[0]), 64'(w));
      check("t4_le0", 64'(nle[0]), 64'(1));
      check("t4_busy_len", 64'(busy_cnt), 64'(TOT));

      // CLK_DIV=1, DATA_WIDTH=6 instance
      s_csr.afeSel = 1'b0; s_csr.wrData = 6'b101101; s_csr.start = 1'b1;
      sb = 0; tog_bad = 0; sle = 0; scap = '0; sdone = 1'b0; sp_clk = 1'b0; sp_le = 1'b0;
      for (int i = 0; i < 40 && !sdone; i++) begin
         cycle();
         s_csr.start = 1'b0;
         if (s_csr.busy) begin
            if (sb < 12 && s_clk[0] != 1'(sb % 2)) tog_bad++;
            sb++;
         end
         if (s_clk[0] && !sp_clk) scap = {scap[4:0], s_sdi[0]};
         if (s_le[0] && !sp_le) sle++;
         sp_clk = s_clk[0];
         sp_le  = s_le[0];
         if (s_csr.done) sdone = 1'b1;
      end
      check("t5_done", 64'(sdone), 64'(1));
      check("t5_busy_len", 64'(sb), 64'(15));
      check("t5_word", 64'(scap), 64'(6'b101101));
      check("t5_toggle", 64'(tog_bad), 64'(0));
      check("t5_le0", 64'(sle), 64'(1));
      check("t5_quiet1", 64'({s_clk[1], s_sdi[1], s_le[1], s_csr.overrun}), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
